// File: rtl/sign_ext.sv
// Registered immediate sign-extension unit for the RISC-Z ALU B operand.
// Optional zero-extension mode: define SIGN_EXT_ZERO_EXT_EN to add ZeroExt.
module sign_ext #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              En,
  input  logic [1:0]        SignOp,
  input  logic [9:0]        In0,
  input  logic [3:0]        In1,
  input  logic [5:0]        In2,
  input  logic [7:0]        In3,
`ifdef SIGN_EXT_ZERO_EXT_EN
  input  logic              ZeroExt,
`endif
  output logic [DATA_W-1:0] ExOut,
  output logic              ExValid
);

  logic [3:0]        sel;
  logic              sx;
  logic [DATA_W-1:0] res;

  assign sel = 4'b0001 << SignOp;

`ifdef SIGN_EXT_ZERO_EXT_EN
  assign sx = ~ZeroExt;
`else
  assign sx = 1'b1;
`endif

  // Fill the word with the extension bit, then overlay the raw field.
  always_comb begin
    res = '0;
    unique case (1'b1)
      sel[0]: begin
        res      = {DATA_W{sx & In0[9]}};
        res[9:0] = In0;
      end
      sel[1]: begin
        res      = {DATA_W{sx & In1[3]}};
        res[3:0] = In1;
      end
      sel[2]: begin
        res      = {DATA_W{sx & In2[5]}};
        res[5:0] = In2;
      end
      sel[3]: begin
        res      = {DATA_W{sx & In3[7]}};
        res[7:0] = In3;
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ExOut   <= '0;
      ExValid <= 1'b0;
    end else if (En) begin
      ExOut   <= res;
      ExValid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sign_ext.sv
// Scoreboard bench for sign_ext: driver pushes model results,
// monitor pops and compares after every rising edge.
module tb_sign_ext;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  signop = '0;
  logic [9:0]  in0 = '0;
  logic [3:0]  in1 = '0;
  logic [5:0]  in2 = '0;
  logic [7:0]  in3 = '0;
  logic        zeroext = 1'b0;
  logic [15:0] exout;
  logic        exvalid;

  int tests = 0;
  int fails = 0;

  logic [16:0] q[$];
  logic        mv = 1'b0;
  logic [15:0] mo = '0;

  sign_ext #(.DATA_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .En(en),
    .SignOp(signop),
    .In0(in0),
    .In1(in1),
    .In2(in2),
    .In3(in3),
`ifdef SIGN_EXT_ZERO_EXT_EN
    .ZeroExt(zeroext),
`endif
    .ExOut(exout),
    .ExValid(exvalid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_ext(
    input logic [1:0] op, input logic [9:0] a, input logic [3:0] b,
    input logic [5:0] c, input logic [7:0] d, input logic z);
    int v;
    int w;
    int f;
    case (op)
      2'd0: begin f = int'(a); w = 10; end
      2'd1: begin f = int'(b); w = 4; end
      2'd2: begin f = int'(c); w = 6; end
      default: begin f = int'(d); w = 8; end
    endcase
`ifndef SIGN_EXT_ZERO_EXT_EN
    z = 1'b0;
`endif
    v = f;
    if (!z && f >= (1 << (w - 1)))
      v = f - (1 << w);
    return 16'(v);
  endfunction

  task automatic step(
    input logic r, input logic e, input logic [1:0] op,
    input logic [9:0] a, input logic [3:0] b, input logic [5:0] c,
    input logic [7:0] d, input logic z, input int want);
    @(negedge clk);
    rst_n = r; en = e; signop = op;
    in0 = a; in1 = b; in2 = c; in3 = d; zeroext = z;
    if (!r) begin
      mv = 1'b0; mo = '0;
    end else if (e) begin
      mv = 1'b1; mo = ref_ext(op, a, b, c, d, z);
    end
    if (want >= 0)
      q.push_back({mv, 16'(want)});
    else
      q.push_back({mv, mo});
  endtask

  task automatic rnd_step(input logic r, input logic e);
    step(r, e, 2'($urandom_range(0, 3)), 10'($urandom), 4'($urandom),
         6'($urandom), 8'($urandom), 1'b0, -1);
  endtask

  initial begin : monitor
    logic [16:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_v = q.pop_front();
        tests++;
        if ({exvalid, exout} !== exp_v) begin
          fails++;
          $display("FAIL cmp%0d: got valid=%0b out=%h, want valid=%0b out=%h",
                   tests, exvalid, exout, exp_v[16], exp_v[15:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // reset with enable high and busy inputs
    step(0, 1, 2'd3, 10'h3FF, 4'hF, 6'h3F, 8'hFF, 0, 0);
    step(0, 1, 2'd0, 10'h155, 4'h5, 6'h15, 8'h55, 0, 0);
    // positive fields
    step(1, 1, 2'd0, 10'h0BA, 4'h6, 6'h0D, 8'h25, 0, 16'h00BA);
    step(1, 1, 2'd1, 10'h0BA, 4'h6, 6'h0D, 8'h25, 0, 16'h0006);
    step(1, 1, 2'd2, 10'h0BA, 4'h6, 6'h0D, 8'h25, 0, 16'h000D);
    step(1, 1, 2'd3, 10'h0BA, 4'h6, 6'h0D, 8'h25, 0, 16'h0025);
    // negative fields
    step(1, 1, 2'd0, 10'h2BA, 4'hE, 6'h2D, 8'hA5, 0, 16'hFEBA);
    step(1, 1, 2'd1, 10'h2BA, 4'hE, 6'h2D, 8'hA5, 0, 16'hFFFE);
    step(1, 1, 2'd2, 10'h2BA, 4'hE, 6'h2D, 8'hA5, 0, 16'hFFED);
    step(1, 1, 2'd3, 10'h2BA, 4'hE, 6'h2D, 8'hA5, 0, 16'hFFA5);
    // hold
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 2'(i), 10'($urandom), 4'($urandom), 6'($urandom),
           8'($urandom), 0, 16'hFFA5);
    end
    step(1, 1, 2'd1, 10'h000, 4'h3, 6'h00, 8'h00, 0, 16'h0003);
    // isolation and boundaries
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 2'd1, 10'($urandom), 4'h8, 6'($urandom),
           8'($urandom), 0, 16'hFFF8);
    end
    step(1, 1, 2'd1, 10'($urandom), 4'h7, 6'($urandom), 8'($urandom), 0, 16'h0007);
    step(1, 1, 2'd0, 10'h3FF, 4'h0, 6'h00, 8'h00, 0, 16'hFFFF);
    step(1, 1, 2'd2, 10'h3FF, 4'hF, 6'h00, 8'hFF, 0, 16'h0000);
    step(1, 1, 2'd3, 10'h000, 4'h0, 6'h00, 8'h7F, 0, 16'h007F);
    // reset mid-stream, then capture needs En
    step(0, 1, 2'd3, 10'h000, 4'h0, 6'h00, 8'hA5, 0, 0);
    step(1, 0, 2'd3, 10'h000, 4'h0, 6'h00, 8'hA5, 0, 0);
    step(1, 1, 2'd3, 10'h000, 4'h0, 6'h00, 8'hA5, 0, 16'hFFA5);
`ifdef SIGN_EXT_ZERO_EXT_EN
    step(1, 1, 2'd3, 10'h000, 4'h0, 6'h00, 8'hA5, 1, 16'h00A5);
    step(1, 1, 2'd3, 10'h000, 4'h0, 6'h00, 8'hA5, 0, 16'hFFA5);
    step(1, 1, 2'd0, 10'h2BA, 4'h0, 6'h00, 8'h00, 1, 16'h02BA);
`endif
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      rnd_step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0));
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sign_ext.md
Name: sign_ext

Overview:
- Registered immediate sign-extension unit for the RISC-Z CPU datapath; sits between instruction decode and the ALU B-operand mux.
- Selects one of four immediate fields (10/4/6/8 bit) with a 2-bit SignOp code.
- Sign-extends the selected field to a 16-bit word, registered on the clock.

Parameters:
- DATA_W, 16, output word width; must be >= 10 (the widest input field).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- En  input  1  update enable; when low, ExOut and ExValid hold their values.
- SignOp  input  2  field select: 0=In0, 1=In1, 2=In2, 3=In3.
- In0  input  10  10-bit immediate field.
- In1  input  4  4-bit immediate field.
- In2  input  6  6-bit immediate field.
- In3  input  8  8-bit immediate field.
- ExOut  output  DATA_W  registered extended result.
- ExValid  output  1  high when ExOut holds a result captured since the last reset.

Behaviour:
- Reset: on a rising edge with rst_n=0, ExOut <= 0 and ExValid <= 0. Reset overrides En.
- Combinational selection:
  - SignOp=0: result = {DATA_W-10 copies of In0[9], In0}.
  - SignOp=1: result = {DATA_W-4 copies of In1[3], In1}.
  - SignOp=2: result = {DATA_W-6 copies of In2[5], In2}.
  - SignOp=3: result = {DATA_W-8 copies of In3[7], In3}.
- Register update: on a rising edge with rst_n=1 and En=1, ExOut <= result and ExValid <= 1.
- Hold: on a rising edge with rst_n=1 and En=0, ExOut and ExValid keep their previous values.
- Latency: exactly one clock from inputs/SignOp to ExOut. No combinational path from any input to any output.
- Field isolation: inputs not selected by SignOp must not affect the result.
- Boundary values:
  - Field MSB = 0: upper bits are zero, e.g. In1=0111 gives 0x0007.
  - Field MSB = 1: upper bits are one, e.g. In1=1000 gives 0xFFF8.
  - All-ones field gives 0xFFFF; all-zeros field gives 0x0000.
- SignOp changing every cycle: each cycle's result reflects only the SignOp and fields present at that edge.
- Reset mid-stream: the result pending at a reset edge is discarded. The first post-reset capture needs En=1.

Optional Feature:
- Macro: SIGN_EXT_ZERO_EXT_EN.
- When defined:
  - Adds input port ZeroExt (1 bit).
  - ZeroExt=1: the selected field is zero-extended instead of sign-extended, e.g. In3=10100101 gives 0x00A5.
  - ZeroExt=0: identical to base behaviour.
  - ZeroExt obeys the same one-cycle latency and En gating.
- When undefined: the port does not exist and extension is always signed.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with En=1 and non-zero inputs -> ExOut=0x0000, ExValid=0; first edge after rst_n=1 -> ExValid=1.
- Positive fields: In0=0010111010, In1=0110, In2=001101, In3=00100101, En=1, SignOp stepped 0..3 one per clock -> ExOut=0x00BA, 0x0006, 0x000D, 0x0025, each one clock after its SignOp.
- Negative fields: In0=1010111010, In1=1110, In2=101101, In3=10100101, SignOp stepped 0..3 -> ExOut=0xFEBA, 0xFFFE, 0xFFED, 0xFFA5.
- Hold: capture 0xFFA5, then drop En and change SignOp and all inputs for 3 clocks -> ExOut stays 0xFFA5; raise En -> new value appears next edge.
- Isolation/boundary: SignOp=1, In1=1000, toggle In0/In2/In3 randomly -> ExOut=0xFFF8 constant; In1=0111 -> 0x0007.
- Optional (SIGN_EXT_ZERO_EXT_EN): SignOp=3, In3=10100101, ZeroExt=1 -> 0x00A5; ZeroExt=0 -> 0xFFA5.
